// File: rtl/highscore_pkg.sv
// Shared types and constants for the top-N high-score table.
// The seed list is only used when HIGHSCORE_SEED_EN is defined.
package highscore_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEARCH,
        SHIFT,
        WRITE,
        DONE
    } hs_state_t;

    localparam int HS_SCORE_W   = 8;
    localparam int HS_DEPTH     = 5;
    localparam int HS_RANK_NONE = 0;

    // Seed values are listed best-first; positions past the list reset to 0.
    localparam int HS_SEED_LEN            = 5;
    localparam int HS_SEED [HS_SEED_LEN]  = '{141, 33, 20, 15, 11};

endpackage

// File: rtl/highscore_table_if.sv
// Request/response handshake between the game-over logic and the high-score table.
interface highscore_table_if
    import highscore_pkg::*;
#(
    parameter int SCORE_W = HS_SCORE_W,
    parameter int DEPTH   = HS_DEPTH
);
    localparam int RANK_W = $clog2(DEPTH + 1);

    logic               update;
    logic [SCORE_W-1:0] curr_score;
    logic               busy;
    logic               done;
    logic [RANK_W-1:0]  rank;

    modport master (output update, curr_score, input busy, done, rank);
    modport slave  (input update, curr_score, output busy, done, rank);

endinterface

// File: rtl/highscore_table.sv
// Sequential top-N high-score table: one compare or one shift per clock.
// Define HIGHSCORE_SEED_EN to reset the table to the package seed list instead of zeros.
module highscore_table
    import highscore_pkg::*;
#(
    parameter int SCORE_W = HS_SCORE_W,
    parameter int DEPTH   = HS_DEPTH,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int RANK_W  = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    highscore_table_if.slave         hs,
    input  logic [IDX_W-1:0]         rd_idx,
    output logic [SCORE_W-1:0]       rd_score,
    output logic [DEPTH*SCORE_W-1:0] hi_flat
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    hs_state_t          state_reg;
    logic [SCORE_W-1:0] cand_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic [IDX_W-1:0]   pos_reg;
    logic               busy_reg;
    logic               done_reg;
    logic [RANK_W-1:0]  rank_reg;

    logic [SCORE_W-1:0] entry [DEPTH];

    // Each entry owns its register; it only moves on a SHIFT aimed at it or the final WRITE.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [SCORE_W-1:0] score_reg;
            logic [SCORE_W-1:0] rst_val;
            logic [SCORE_W-1:0] prev;

`ifdef HIGHSCORE_SEED_EN
            if (gi < HS_SEED_LEN) begin : g_seed
                assign rst_val = SCORE_W'(HS_SEED[gi]);
            end else begin : g_zero
                assign rst_val = '0;
            end
`else
            assign rst_val = '0;
`endif

            if (gi == 0) begin : g_top
                assign prev = score_reg;
            end else begin : g_below
                assign prev = entry[gi-1];
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    score_reg <= rst_val;
                end else if (state_reg == SHIFT && idx_reg == IDX_W'(gi)) begin
                    score_reg <= prev;
                end else if (state_reg == WRITE && pos_reg == IDX_W'(gi)) begin
                    score_reg <= cand_reg;
                end
            end

            assign entry[gi]                          = score_reg;
            assign hi_flat[gi*SCORE_W +: SCORE_W]     = score_reg;
        end
    endgenerate

    assign rd_score = (32'(rd_idx) < DEPTH) ? entry[rd_idx] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cand_reg  <= '0;
            idx_reg   <= '0;
            pos_reg   <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            rank_reg  <= RANK_W'(HS_RANK_NONE);
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (hs.update) begin
                        cand_reg  <= hs.curr_score;
                        idx_reg   <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= SEARCH;
                    end
                end
                SEARCH: begin
                    // Strict compare: an equal score stays below the incumbent.
                    if (cand_reg > entry[idx_reg]) begin
                        pos_reg <= idx_reg;
                        if (idx_reg == LAST_IDX) begin
                            state_reg <= WRITE;
                        end else begin
                            idx_reg   <= LAST_IDX;
                            state_reg <= SHIFT;
                        end
                    end else if (idx_reg == LAST_IDX) begin
                        rank_reg  <= RANK_W'(HS_RANK_NONE);
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else begin
                        idx_reg <= idx_reg + IDX_W'(1);
                    end
                end
                SHIFT: begin
                    if ((idx_reg - IDX_W'(1)) == pos_reg) begin
                        state_reg <= WRITE;
                    end else begin
                        idx_reg <= idx_reg - IDX_W'(1);
                    end
                end
                WRITE: begin
                    rank_reg  <= RANK_W'(pos_reg) + RANK_W'(1);
                    done_reg  <= 1'b1;
                    state_reg <= DONE;
                end
                DONE: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    busy_reg  <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign hs.busy = busy_reg;
    assign hs.done = done_reg;
    assign hs.rank = rank_reg;

endmodule
